// File: rtl/trv_arbiter_pkg.sv
// trv_arbiter shared types and field layout.
// TID sits in the low bits of both the init request and the traversal response.
package trv_arbiter_pkg;

   localparam int NUM_TRV_UNITS    = 4;
   localparam int TID_WIDTH        = 4;
   localparam int INIT_REQ_WIDTH   = 32;
   localparam int TRV_RESP_WIDTH   = 32;
   localparam int INIT_REQ_TID_LSB = 0;
   localparam int TRV_RESP_TID_LSB = 0;

   typedef logic [TID_WIDTH-1:0] tid_t;

   // A unit count is legal when every unit index is encodable as a TID.
   function automatic bit tid_fits(input int n);
      return (n >= 2) && (n <= (1 << TID_WIDTH));
   endfunction

   localparam bit TID_WIDTH_OK = tid_fits(NUM_TRV_UNITS);

endpackage

// File: rtl/trv_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first set request at or after ptr.
// Produces a one-hot grant and the binary winner index.
module rr_arbiter #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] win,
   output logic         valid
);

   // Scan N positions starting at ptr, wrapping modulo N.
   always_comb begin
      int idx;
      grant = '0;
      win   = '0;
      valid = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!valid && req[idx]) begin
            valid      = 1'b1;
            grant[idx] = 1'b1;
            win        = W'(idx);
         end
      end
   end

endmodule

// File: rtl/trv_arbiter.sv
// trv_arbiter: shares one traversal core between NUM_UNITS reorder units.
// Build option TRV_ARBITER_TID_CHECK_EN adds a sticky TID error flag and drops stray responses.
module trv_arbiter
   import trv_arbiter_pkg::*;
#(
   parameter int NUM_UNITS     = NUM_TRV_UNITS,
   parameter int CORE_CAPACITY = 32,
   localparam int UW = $clog2(NUM_UNITS),
   localparam int CW = $clog2(CORE_CAPACITY + 1)
) (
   input  logic                                clk,
   input  logic                                arst,
   input  logic [NUM_UNITS-1:0]                req_empty_n,
   output logic [NUM_UNITS-1:0]                req_read,
   input  logic [NUM_UNITS*INIT_REQ_WIDTH-1:0] req_dout,
   input  logic                                core_req_full_n,
   output logic                                core_req_write,
   output logic [INIT_REQ_WIDTH-1:0]           core_req_din,
   input  logic                                core_resp_empty_n,
   output logic                                core_resp_read,
   input  logic [TRV_RESP_WIDTH-1:0]           core_resp_dout,
   input  logic [NUM_UNITS-1:0]                resp_full_n,
   output logic [NUM_UNITS-1:0]                resp_write,
   output logic [TRV_RESP_WIDTH-1:0]           resp_din,
   output logic [CW-1:0]                       outstanding,
   output logic                                tid_err
);

   if (!tid_fits(NUM_UNITS)) begin : g_tid_width_chk
      $error("TID_WIDTH cannot encode NUM_UNITS");
   end

   logic                      out_valid;
   logic [INIT_REQ_WIDTH-1:0] out_data;
   logic [UW-1:0]             rr_ptr;
   logic [UW-1:0]             nxt_ptr;
   logic [CW-1:0]             credits;
   logic [NUM_UNITS-1:0]      rr_grant;
   logic [UW-1:0]             win;
   logic                      any_req;
   logic [INIT_REQ_WIDTH-1:0] win_data;
   logic                      stage_free;
   logic                      credit_ok;
   logic                      grant_en;
   tid_t                      dst;
   logic [NUM_UNITS-1:0]      dst_oh;
   logic                      in_range;
   logic                      deliver;
   logic                      dec;

   rr_arbiter #(
      .N(NUM_UNITS)
   ) u_rr (
      .req  (req_empty_n),
      .ptr  (rr_ptr),
      .grant(rr_grant),
      .win  (win),
      .valid(any_req)
   );

   assign stage_free = ~out_valid | core_req_full_n;
   assign credit_ok  = credits < CW'(CORE_CAPACITY);
   assign grant_en   = ~arst & stage_free & credit_ok & any_req;
   assign win_data   = req_dout[int'(win)*INIT_REQ_WIDTH +: INIT_REQ_WIDTH];
   assign nxt_ptr    = (int'(win) == NUM_UNITS - 1) ? '0 : win + UW'(1);

   assign req_read       = grant_en ? rr_grant : '0;
   assign core_req_write = out_valid;
   assign core_req_din   = out_data;
   assign outstanding    = credits;

   // One-register output stage towards the core request FIFO.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (grant_en) begin
         out_valid <= 1'b1;
         out_data  <= win_data;
      end else if (core_req_full_n) begin
         out_valid <= 1'b0;
      end
   end

   // Round-robin pointer moves just past the last winner.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rr_ptr <= '0;
      end else if (grant_en) begin
         rr_ptr <= nxt_ptr;
      end
   end

   assign dst = core_resp_dout[TRV_RESP_TID_LSB +: TID_WIDTH];

   // Decode the response TID; an out-of-range TID yields an all-zero vector.
   always_comb begin
      dst_oh = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         dst_oh[u] = (int'(dst) == u);
      end
   end

   assign in_range   = |dst_oh;
   assign deliver    = ~arst & core_resp_empty_n & |(dst_oh & resp_full_n);
   assign resp_write = deliver ? dst_oh : '0;
   assign resp_din   = arst ? '0 : core_resp_dout;

`ifdef TRV_ARBITER_TID_CHECK_EN
   logic discard;
   logic bad_req;
   logic bad_resp;

   assign bad_resp = ~arst & core_resp_empty_n & ~in_range;
   assign discard  = bad_resp;
   assign bad_req  = grant_en &
      (win_data[INIT_REQ_TID_LSB +: TID_WIDTH] != TID_WIDTH'(win));
   assign core_resp_read = deliver | discard;

   // Sticky flag for a mis-tagged request or a stray response.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         tid_err <= 1'b0;
      end else if (bad_req | bad_resp) begin
         tid_err <= 1'b1;
      end
   end
`else
   assign core_resp_read = deliver;
   assign tid_err        = 1'b0;
`endif

   assign dec = core_resp_read & (credits != '0);

   // Rays in flight: credit taken at grant, returned on response pop.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         credits <= '0;
      end else begin
         unique case ({grant_en, dec})
            2'b10:   credits <= credits + CW'(1);
            2'b01:   credits <= credits - CW'(1);
            default: credits <= credits;
         endcase
      end
   end

endmodule

// File: tb/tb_trv_arbiter.sv
// Self-checking bench for trv_arbiter with a reference model and request scoreboard.
// Run with or without TRV_ARBITER_TID_CHECK_EN.
module tb_trv_arbiter;

   localparam int N   = 4;
   localparam int CAP = 8;

   logic          clk = 1'b0;
   logic          arst;
   logic [N-1:0]  req_empty_n;
   logic [N-1:0]  req_read;
   logic [N*32-1:0] req_dout;
   logic          core_req_full_n;
   logic          core_req_write;
   logic [31:0]   core_req_din;
   logic          core_resp_empty_n;
   logic          core_resp_read;
   logic [31:0]   core_resp_dout;
   logic [N-1:0]  resp_full_n;
   logic [N-1:0]  resp_write;
   logic [31:0]   resp_din;
   logic [3:0]    outstanding;
   logic          tid_err;

   trv_arbiter #(
      .NUM_UNITS    (N),
      .CORE_CAPACITY(CAP)
   ) dut (
      .clk              (clk),
      .arst             (arst),
      .req_empty_n      (req_empty_n),
      .req_read         (req_read),
      .req_dout         (req_dout),
      .core_req_full_n  (core_req_full_n),
      .core_req_write   (core_req_write),
      .core_req_din     (core_req_din),
      .core_resp_empty_n(core_resp_empty_n),
      .core_resp_read   (core_resp_read),
      .core_resp_dout   (core_resp_dout),
      .resp_full_n      (resp_full_n),
      .resp_write       (resp_write),
      .resp_din         (resp_din),
      .outstanding      (outstanding),
      .tid_err          (tid_err)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   int          m_ptr, m_outv, m_out, m_tid_err;
   int          m_seq[N];
   logic [N-1:0] m_bad;
   logic [31:0] q[$];

   function automatic logic [31:0] mk(input int u);
      logic [31:0] d;
      d = {16'(m_seq[u]), 8'hC0 + 8'(u), 4'h0, 4'(u)};
      if (m_bad[u]) d[3:0] = d[3:0] ^ 4'h1;
      return d;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_outv = 0; m_out = 0; m_tid_err = 0; m_bad = '0;
      for (int u = 0; u < N; u++) m_seq[u] = u * 16;
      q.delete();
   endtask

   task automatic cyc(input logic [N-1:0] ren, input logic fn, input logic rv,
                      input logic [3:0] rtid, input logic [N-1:0] rf);
      logic [31:0] rdata, gdata, exp_din;
      logic        free, g, f, dlv, crr;
      int          w, k;
      logic [N-1:0] exp_rr, exp_rw;
      req_empty_n = ren; core_req_full_n = fn; core_resp_empty_n = rv;
      rdata = {8'h5A, 8'(n_chk), 12'h0, rtid};
      core_resp_dout = rdata; resp_full_n = rf;
      for (int u = 0; u < N; u++) req_dout[u*32 +: 32] = mk(u);
      #1;
      free = (m_outv == 0) || fn;
      g = free && (m_out < CAP) && (ren != 0);
      f = 1'b0; w = 0;
      for (int i = 0; i < N; i++) begin
         k = (m_ptr + i) % N;
         if (!f && ren[k]) begin f = 1'b1; w = k; end
      end
      exp_rr = g ? N'(1 << w) : '0;
      dlv = rv && (rtid < 4'(N)) && rf[rtid[1:0]];
      crr = dlv;
`ifdef TRV_ARBITER_TID_CHECK_EN
      crr = dlv || (rv && rtid >= 4'(N));
`endif
      exp_rw = dlv ? N'(1 << rtid[1:0]) : '0;
      n_chk++;
      if (req_read !== exp_rr) $display("FAIL req_read: got %b want %b", req_read, exp_rr);
      else n_pass++;
      n_chk++;
      if (core_resp_read !== crr) $display("FAIL core_resp_read: got %b want %b", core_resp_read, crr);
      else n_pass++;
      n_chk++;
      if (resp_write !== exp_rw) $display("FAIL resp_write: got %b want %b", resp_write, exp_rw);
      else n_pass++;
      n_chk++;
      if (resp_din !== rdata) $display("FAIL resp_din: got %h want %h", resp_din, rdata);
      else n_pass++;
      n_chk++;
      if (core_req_write !== (m_outv != 0)) $display("FAIL core_req_write: got %b want %0d", core_req_write, m_outv);
      else n_pass++;
      if (m_outv != 0) begin
         exp_din = (q.size() > 0) ? q[0] : 'x;
         n_chk++;
         if (q.size() == 0 || core_req_din !== exp_din) $display("FAIL core_req_din: got %h want %h", core_req_din, exp_din);
         else n_pass++;
      end
      n_chk++;
      if (outstanding !== 4'(m_out)) $display("FAIL outstanding: got %0d want %0d", outstanding, m_out);
      else n_pass++;
      n_chk++;
      if (tid_err !== (m_tid_err != 0)) $display("FAIL tid_err: got %b want %0d", tid_err, m_tid_err);
      else n_pass++;
      if (m_outv != 0 && fn) void'(q.pop_front());
      if (g) begin
         gdata = mk(w);
         q.push_back(gdata);
`ifdef TRV_ARBITER_TID_CHECK_EN
         if (gdata[3:0] != 4'(w)) m_tid_err = 1;
`endif
         m_seq[w]++;
         m_ptr = (w + 1) % N;
         m_outv = 1;
      end else if (fn) begin
         m_outv = 0;
      end
`ifdef TRV_ARBITER_TID_CHECK_EN
      if (rv && rtid >= 4'(N)) m_tid_err = 1;
`endif
      m_out = m_out + (g ? 1 : 0) - ((crr && m_out != 0) ? 1 : 0);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (m_out != 0 || m_outv != 0); i++)
         cyc('0, 1'b1, m_out != 0, 4'(i % N), '1);
   endtask

   task automatic do_reset();
      arst = 1'b1;
      #1;
      n_chk++;
      if ({req_read, core_req_write, core_resp_read, resp_write} !== '0)
         $display("FAIL reset_handshake: got %b %b %b %b want all 0",
                  req_read, core_req_write, core_resp_read, resp_write);
      else n_pass++;
      n_chk++;
      if ({core_req_din, resp_din} !== '0)
         $display("FAIL reset_data: got %h %h want 0", core_req_din, resp_din);
      else n_pass++;
      n_chk++;
      if ({outstanding, tid_err} !== '0)
         $display("FAIL reset_state: got %0d %b want 0", outstanding, tid_err);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      arst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      req_empty_n = '1; core_req_full_n = 1'b1; core_resp_empty_n = 1'b1;
      core_resp_dout = 32'h0000_0001; resp_full_n = '1; req_dout = '1;
      do_reset();
   endtask

   task automatic test_round_robin();
      repeat (5) cyc('1, 1'b1, 1'b0, 4'd0, '1);
      drain();
   endtask

   task automatic test_single_unit();
      repeat (5) cyc(4'b0100, 1'b1, 1'b0, 4'd0, '1);
      cyc('1, 1'b1, 1'b0, 4'd0, '1);
      drain();
   endtask

   task automatic test_capacity();
      repeat (10) cyc('1, 1'b1, 1'b0, 4'd0, '1);
      n_chk++;
      if (outstanding !== 4'd8) $display("FAIL cap_full: got %0d want 8", outstanding);
      else n_pass++;
      cyc('1, 1'b1, 1'b1, 4'd0, '1);
      cyc('1, 1'b1, 1'b0, 4'd0, '1);
      cyc('1, 1'b1, 1'b0, 4'd0, '1);
      drain();
   endtask

   task automatic test_backpressure();
      cyc('1, 1'b1, 1'b0, 4'd0, '1);
      repeat (3) cyc('1, 1'b0, 1'b0, 4'd0, '1);
      cyc('1, 1'b1, 1'b0, 4'd0, '1);
      drain();
   endtask

   task automatic test_resp_route();
      cyc(4'b0010, 1'b1, 1'b0, 4'd0, '1);
      repeat (2) cyc('0, 1'b1, 1'b1, 4'd1, 4'b1101);
      cyc('0, 1'b1, 1'b1, 4'd1, '1);
      drain();
   endtask

   task automatic test_tid_range();
      logic exp_err;
      cyc(4'b0001, 1'b1, 1'b0, 4'd0, '1);
      cyc('0, 1'b1, 1'b1, 4'd5, '1);
      cyc('0, 1'b1, 1'b0, 4'd0, '1);
      m_bad = 4'b0100;
      cyc(4'b0100, 1'b1, 1'b0, 4'd0, '1);
      m_bad = '0;
      cyc('0, 1'b1, 1'b0, 4'd0, '1);
`ifdef TRV_ARBITER_TID_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      n_chk++;
      if (tid_err !== exp_err) $display("FAIL tid_err_sticky: got %b want %b", tid_err, exp_err);
      else n_pass++;
      cyc('1, 1'b1, 1'b0, 4'd0, '1);
      req_empty_n = '1; core_resp_empty_n = 1'b1; core_resp_dout = 32'h1;
      do_reset();
   endtask

   task automatic test_random();
      logic rv;
      for (int i = 0; i < 60; i++) begin
         rv = (m_out != 0) && ($urandom_range(0, 2) != 0);
         cyc(N'($urandom), $urandom_range(0, 3) != 0, rv,
             4'($urandom_range(0, N - 1)), N'($urandom) | N'($urandom));
      end
      drain();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_round_robin();
      test_single_unit();
      test_capacity();
      test_backpressure();
      test_resp_route();
      test_tid_range();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

endmodule
